pdm_core_mp: RTL and testbench
==============================

// Module: pdm_core_mp
// PURPOSE
//  Parametrised synthesizable packet demux core: receives bnd_plse-framed packets on a
//  single byte stream, routes each by its header byte to one of NUM_PORTS output ports,
//  buffers per port, and replays each packet with the newdata_len/proceed handshake.
//  Successor of the fixed 4-port behavioural core; adds per-port buffering limits,
//  drop/error reporting and a configurable ack delay.
// PARAMETERS
//  NUM_PORTS   4    number of output ports; valid header values 1..NUM_PORTS
//  DATA_W      8    data byte width
//  MAX_PKT     16   max payload bytes per packet (header excluded)
//  LEN_W       5    newdata_len width; must satisfy 2**LEN_W > MAX_PKT
//  PORT_DEPTH  32   per-port data FIFO depth in bytes (>= MAX_PKT, power of 2)
//  PORT_PKTS   4    per-port length FIFO depth in packets (power of 2)
//  ACK_DELAY   1    cycles from end-of-packet pulse to ack (>= 1)
// PORTS
//  clk          in   1                  clock, all logic on rising edge
//  rst_b        in   1                  reset, asynchronous, active-high
//  bnd_plse     in   1                  packet boundary pulse (first and last byte)
//  data_in      in   DATA_W             input byte stream
//  ack          out  1                  one-cycle packet-end acknowledge
//  pkt_drop     out  1                  one-cycle pulse: packet discarded
//  drop_code    out  2                  valid with pkt_drop: 1 bad port, 2 too long, 3 no space
//  newdata_len  out  NUM_PORTS*LEN_W    per-port length announce; port p at slice p-1
//  proceed      in   NUM_PORTS          per-port downstream go
//  data_out     out  NUM_PORTS*DATA_W   per-port output byte; port p at slice p-1
// BEHAVIOUR
//  Reset (rst_b=1, async): all outputs 0; all FIFOs/pointers cleared; in-flight packets lost.
//  Input framing: cycle with bnd_plse=1 in RX_IDLE carries header (dst port). Each following
//   cycle's data_in is a payload byte; the next bnd_plse=1 cycle carries the last payload
//   byte and ends the packet. Min payload 1 (pulses on consecutive cycles).
//  Input FSM: RX_IDLE -> RX_DATA on header; RX_DATA -> RX_IDLE on end pulse.
//   - At header: accept if 1<=hdr<=NUM_PORTS, free bytes >= MAX_PKT and length FIFO not full;
//     else enter RX_DATA in discard mode (code 1 bad port, 3 no space; bad port wins).
//   - Accepted bytes are written at a speculative write pointer; committed pointer and length
//     entry updated only on end pulse. Payload count > MAX_PKT -> discard mode, code 2,
//     speculative pointer rolled back to committed at end pulse.
//   - pkt_drop/drop_code pulse in the cycle after the end pulse, for discarded packets only.
//  Ack: ack=1 for exactly one cycle, ACK_DELAY cycles after every end pulse (accepted or
//   dropped); implemented as delay line so back-to-back packets each get one ack.
//  Output FSM per port: O_IDLE -> O_ANN when length FIFO non-empty.
//   O_ANN (1 cycle): newdata_len=len, else newdata_len=0.
//   O_WAIT: hold until proceed sampled 1 (proceed during O_ANN ignored).
//   O_GAP (1 cycle): data_out=0.  O_SEND: len consecutive cycles of bytes, in arrival order.
//   Then O_IDLE for >= 1 cycle; data_out=0 whenever not in O_SEND.
//  Commit latency: packet ending in cycle T is announceable from cycle T+2 on an idle port.
//  Simultaneous: write (input) and read (output) of same port FIFO in one cycle both legal;
//   free-space check uses committed read pointer of that cycle. Ports fully independent.
//  Header values >NUM_PORTS or 0 never reach any port. Reset mid-packet or mid-send:
//   everything aborts, no ack, no pkt_drop issued for the aborted packet.
// TESTING
//  1. hdr=2, payload A1,A2,A3 -> ack 1 cycle after end; port2 newdata_len=3 once; after
//     proceed_2, gap cycle, then A1,A2,A3; other ports stay 0.
//  2. hdr=5 (NUM_PORTS=4), 4 bytes -> pkt_drop=1 code 1, ack still pulses, no port announces.
//  3. hdr=1, 17 payload bytes (MAX_PKT=16) -> pkt_drop code 2; following 2-byte pkt to port1
//     announces len 2 with correct data (rollback verified).
//  4. Five 16-byte pkts to port3, proceed_3 held 0 -> first two accepted (PORT_DEPTH=32),
//     3rd..5th drop code 3; releasing proceed_3 yields exactly two packets.
//  5. Back-to-back 1-byte packets to ports 1..4, ACK_DELAY=3 -> four acks, each 3 cycles
//     after its end pulse; all four ports announce len 1 concurrently.
//  6. Assert rst_b during port4 O_SEND -> all outputs 0 same cycle; after release, new pkt
//     to port4 announces correctly with no stale data.

Source files
------------

// File: rtl/pdm_core_mp.sv
// pdm_core_mp: routes framed packets by header byte to per-port FIFOs.
// Ports: clk, rst_b (async, active-high), bnd_plse/data_in framed input,
// ack, pkt_drop/drop_code status, per-port newdata_len/proceed/data_out.
module pdm_core_mp #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_PKT    = 16,
  parameter int LEN_W      = 5,
  parameter int PORT_DEPTH = 32,
  parameter int PORT_PKTS  = 4,
  parameter int ACK_DELAY  = 1
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        bnd_plse,
  input  logic [DATA_W-1:0]           data_in,
  output logic                        ack,
  output logic                        pkt_drop,
  output logic [1:0]                  drop_code,
  output logic [NUM_PORTS*LEN_W-1:0]  newdata_len,
  input  logic [NUM_PORTS-1:0]        proceed,
  output logic [NUM_PORTS*DATA_W-1:0] data_out
);
  localparam int PW = $clog2(PORT_DEPTH);
  localparam int LW = $clog2(PORT_PKTS);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(MAX_PKT + 2);

  typedef enum logic {RX_IDLE, RX_DATA} rx_e;
  typedef enum logic [2:0] {
    O_IDLE, O_ANN, O_WAIT, O_GAP, O_SEND
  } o_e;

  rx_e                  rx_state_q, rx_state_d;
  logic [IW-1:0]        rx_port_q, rx_port_d;
  logic                 rx_disc_q, rx_disc_d;
  logic [1:0]           rx_code_q, rx_code_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic                 drop_q, drop_d;
  logic [1:0]           code_q, code_d;
  logic [ACK_DELAY-1:0] ack_sr_q, ack_sr_d;

  logic [PW:0]       wp_spec_q [NUM_PORTS];
  logic [PW:0]       wp_spec_d [NUM_PORTS];
  logic [PW:0]       wp_com_q  [NUM_PORTS];
  logic [PW:0]       wp_com_d  [NUM_PORTS];
  logic [PW:0]       rp_q      [NUM_PORTS];
  logic [PW:0]       rp_d      [NUM_PORTS];
  logic [LW:0]       lwp_q     [NUM_PORTS];
  logic [LW:0]       lwp_d     [NUM_PORTS];
  logic [LW:0]       lrp_q     [NUM_PORTS];
  logic [LW:0]       lrp_d     [NUM_PORTS];
  o_e                o_state_q [NUM_PORTS];
  o_e                o_state_d [NUM_PORTS];
  logic [LEN_W-1:0]  o_len_q   [NUM_PORTS];
  logic [LEN_W-1:0]  o_len_d   [NUM_PORTS];
  logic [LEN_W-1:0]  o_cnt_q   [NUM_PORTS];
  logic [LEN_W-1:0]  o_cnt_d   [NUM_PORTS];

  logic [DATA_W-1:0] mem_q     [NUM_PORTS][PORT_DEPTH];
  logic [LEN_W-1:0]  len_mem_q [NUM_PORTS][PORT_PKTS];

  logic          hdr_ok, space_ok, lfull, end_pls, over;
  logic          wr_en, len_we;
  logic [IW-1:0] hdr_idx;
  logic [PW:0]   used;
  logic [CW-1:0] cnt_nx;

  always_comb begin
    hdr_ok   = (data_in != '0) &&
               (32'(data_in) <= NUM_PORTS);
    hdr_idx  = IW'(data_in - DATA_W'(1));
    used     = wp_com_q[hdr_idx] - rp_q[hdr_idx];
    space_ok = 32'(used) <= PORT_DEPTH - MAX_PKT;
    lfull    = (lwp_q[hdr_idx] - lrp_q[hdr_idx])
               == (LW+1)'(PORT_PKTS);
    end_pls  = (rx_state_q == RX_DATA) && bnd_plse;
    // count saturates one past MAX_PKT: enough to flag overflow
    cnt_nx   = (rx_cnt_q > CW'(MAX_PKT)) ? rx_cnt_q
               : rx_cnt_q + CW'(1);
    over     = cnt_nx > CW'(MAX_PKT);
  end

  always_comb begin
    rx_state_d = rx_state_q;
    if (bnd_plse)
      rx_state_d = (rx_state_q == RX_IDLE) ? RX_DATA : RX_IDLE;
  end

  always_comb begin
    rx_port_d = rx_port_q;
    rx_disc_d = rx_disc_q;
    rx_code_d = rx_code_q;
    rx_cnt_d  = rx_cnt_q;
    wp_spec_d = wp_spec_q;
    wp_com_d  = wp_com_q;
    lwp_d     = lwp_q;
    wr_en     = 1'b0;
    len_we    = 1'b0;
    drop_d    = 1'b0;
    code_d    = 2'd0;
    if (rx_state_q == RX_IDLE) begin
      if (bnd_plse) begin
        rx_port_d = hdr_ok ? hdr_idx : '0;
        rx_cnt_d  = '0;
        rx_disc_d = !(hdr_ok && space_ok && !lfull);
        rx_code_d = hdr_ok ? 2'd3 : 2'd1;
      end
    end else begin
      rx_cnt_d = cnt_nx;
      if (!rx_disc_q && !over) begin
        wr_en = 1'b1;
        wp_spec_d[rx_port_q] =
          wp_spec_q[rx_port_q] + (PW+1)'(1);
      end
      if (!rx_disc_q && over) begin
        rx_disc_d = 1'b1;
        rx_code_d = 2'd2;
      end
      if (bnd_plse) begin
        if (!rx_disc_q && !over) begin
          wp_com_d[rx_port_q] =
            wp_spec_q[rx_port_q] + (PW+1)'(1);
          len_we = 1'b1;
          lwp_d[rx_port_q] =
            lwp_q[rx_port_q] + (LW+1)'(1);
        end else begin
          // discard: drop any speculatively written bytes
          wp_spec_d[rx_port_q] = wp_com_q[rx_port_q];
          drop_d = 1'b1;
          code_d = rx_disc_q ? rx_code_q : 2'd2;
        end
      end
    end
    ack_sr_d[0] = end_pls;
    for (int i = 1; i < ACK_DELAY; i++)
      ack_sr_d[i] = ack_sr_q[i-1];
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_state_d[p] = o_state_q[p];
      unique case (o_state_q[p])
        O_IDLE:
          if (lwp_q[p] != lrp_q[p]) o_state_d[p] = O_ANN;
        O_ANN:  o_state_d[p] = O_WAIT;
        O_WAIT: if (proceed[p]) o_state_d[p] = O_GAP;
        O_GAP:  o_state_d[p] = O_SEND;
        O_SEND:
          if (o_cnt_q[p] == o_len_q[p] - LEN_W'(1))
            o_state_d[p] = O_IDLE;
        default: o_state_d[p] = O_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rp_d[p]    = rp_q[p];
      lrp_d[p]   = lrp_q[p];
      o_len_d[p] = o_len_q[p];
      o_cnt_d[p] = o_cnt_q[p];
      if (o_state_q[p] == O_IDLE &&
          lwp_q[p] != lrp_q[p]) begin
        o_len_d[p] = len_mem_q[p][lrp_q[p][LW-1:0]];
        lrp_d[p]   = lrp_q[p] + (LW+1)'(1);
      end
      if (o_state_q[p] == O_GAP) o_cnt_d[p] = '0;
      if (o_state_q[p] == O_SEND) begin
        rp_d[p]    = rp_q[p] + (PW+1)'(1);
        o_cnt_d[p] = o_cnt_q[p] + LEN_W'(1);
      end
    end
  end

  always_comb begin
    newdata_len = '0;
    data_out    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (o_state_q[p] == O_ANN)
        newdata_len[p*LEN_W +: LEN_W] = o_len_q[p];
      if (o_state_q[p] == O_SEND)
        data_out[p*DATA_W +: DATA_W] =
          mem_q[p][rp_q[p][PW-1:0]];
    end
  end

  assign ack       = ack_sr_q[ACK_DELAY-1];
  assign pkt_drop  = drop_q;
  assign drop_code = code_q;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[rx_port_q][wp_spec_q[rx_port_q][PW-1:0]] <= data_in;
    if (len_we)
      len_mem_q[rx_port_q][lwp_q[rx_port_q][LW-1:0]] <=
        LEN_W'(cnt_nx);
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      rx_state_q <= RX_IDLE;
      rx_port_q  <= '0;
      rx_disc_q  <= 1'b0;
      rx_code_q  <= 2'd0;
      rx_cnt_q   <= '0;
      drop_q     <= 1'b0;
      code_q     <= 2'd0;
      ack_sr_q   <= '0;
      wp_spec_q  <= '{default: '0};
      wp_com_q   <= '{default: '0};
      rp_q       <= '{default: '0};
      lwp_q      <= '{default: '0};
      lrp_q      <= '{default: '0};
      o_state_q  <= '{default: O_IDLE};
      o_len_q    <= '{default: '0};
      o_cnt_q    <= '{default: '0};
    end else begin
      rx_state_q <= rx_state_d;
      rx_port_q  <= rx_port_d;
      rx_disc_q  <= rx_disc_d;
      rx_code_q  <= rx_code_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_q     <= drop_d;
      code_q     <= code_d;
      ack_sr_q   <= ack_sr_d;
      wp_spec_q  <= wp_spec_d;
      wp_com_q   <= wp_com_d;
      rp_q       <= rp_d;
      lwp_q      <= lwp_d;
      lrp_q      <= lrp_d;
      o_state_q  <= o_state_d;
      o_len_q    <= o_len_d;
      o_cnt_q    <= o_cnt_d;
    end
  end
endmodule

// File: tb/tb_pdm_core_mp.sv
// tb_pdm_core_mp: directed and random packets checked cycle by
// cycle against a timestamp-based packet model of pdm_core_mp.
module tb_pdm_core_mp;
  localparam int NP = 4, DW = 8, MP = 16, LW = 5;
  localparam int PD = 32, PP = 4, AD = 3;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic bnd_plse = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [NP-1:0] proceed = '0;
  logic ack, pkt_drop;
  logic [1:0] drop_code;
  logic [NP*LW-1:0] newdata_len;
  logic [NP*DW-1:0] data_out;

  always #5 clk = ~clk;

  pdm_core_mp #(
    .NUM_PORTS(NP), .DATA_W(DW), .MAX_PKT(MP), .LEN_W(LW),
    .PORT_DEPTH(PD), .PORT_PKTS(PP), .ACK_DELAY(AD)
  ) dut (
    .clk(clk), .rst_b(rst_b), .bnd_plse(bnd_plse),
    .data_in(data_in), .ack(ack), .pkt_drop(pkt_drop),
    .drop_code(drop_code), .newdata_len(newdata_len),
    .proceed(proceed), .data_out(data_out)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int tcur = 0;
  logic [NP-1:0] pr_v = '0;
  bit pr_rnd = 0;
  int ann_cnt [NP];
  int drop3_cnt;

  // model: committed packets per port, with end-cycle stamps
  int q_len [NP][$];
  int q_end [NP][$];
  logic [7:0] q_byte [NP][$];
  int ann_c [NP], go_c [NP], cur_len [NP], last_send [NP];
  int sent [NP], comm [NP], pushed [NP], popped [NP];
  bit ack_at [int];
  int drop_at [int];
  bit in_pkt, acc;
  int rx_port, rx_cnt, rx_code;
  logic [7:0] rx_buf [$];
  logic [NP*LW-1:0] e_len;
  logic [NP*DW-1:0] e_data;
  bit e_sent [NP];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h cycle %0d",
             tag, obs, exp, tcur);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      q_len[p].delete(); q_end[p].delete();
      q_byte[p].delete();
      ann_c[p] = -1; go_c[p] = -1; cur_len[p] = 0;
      last_send[p] = -100;
      sent[p] = 0; comm[p] = 0; pushed[p] = 0; popped[p] = 0;
    end
    ack_at.delete(); drop_at.delete();
    in_pkt = 0; acc = 0; rx_buf.delete();
  endtask

  task automatic model_expect(input int t);
    e_len = '0; e_data = '0;
    for (int p = 0; p < NP; p++) begin
      e_sent[p] = 0;
      // announce needs commit >= 2 cycles ago and a prior idle cycle
      if (ann_c[p] < 0 && q_len[p].size() > 0 &&
          q_end[p][0] <= t - 2 && last_send[p] <= t - 2) begin
        ann_c[p] = t; go_c[p] = -1;
        cur_len[p] = q_len[p].pop_front();
        void'(q_end[p].pop_front());
        popped[p]++;
      end
      if (ann_c[p] == t) e_len[p*LW +: LW] = 5'(cur_len[p]);
      if (ann_c[p] >= 0 && go_c[p] >= 0 && t >= go_c[p] + 2) begin
        e_data[p*DW +: DW] = q_byte[p].pop_front();
        e_sent[p] = 1;
      end
    end
  endtask

  task automatic model_ingest(input int t, input logic b,
                              input logic [7:0] d,
                              input logic [NP-1:0] pr);
    for (int p = 0; p < NP; p++) begin
      if (e_sent[p]) begin
        sent[p]++;
        if (t == go_c[p] + 1 + cur_len[p]) begin
          last_send[p] = t; ann_c[p] = -1;
        end
      end else if (ann_c[p] >= 0 && go_c[p] < 0 &&
                   t > ann_c[p] && pr[p]) begin
        go_c[p] = t;
      end
    end
    if (!in_pkt) begin
      if (b) begin
        in_pkt = 1; rx_cnt = 0; rx_buf.delete();
        if (int'(d) < 1 || int'(d) > NP) begin
          acc = 0; rx_code = 1;
        end else begin
          rx_port = int'(d) - 1;
          if (comm[rx_port] - sent[rx_port] > PD - MP ||
              pushed[rx_port] - popped[rx_port] == PP) begin
            acc = 0; rx_code = 3;
          end else acc = 1;
        end
      end
    end else begin
      rx_cnt++;
      rx_buf.push_back(d);
      if (b) begin
        in_pkt = 0;
        ack_at[t + AD] = 1;
        if (acc && rx_cnt <= MP) begin
          q_len[rx_port].push_back(rx_cnt);
          q_end[rx_port].push_back(t);
          foreach (rx_buf[i]) q_byte[rx_port].push_back(rx_buf[i]);
          comm[rx_port] += rx_cnt;
          pushed[rx_port]++;
        end else begin
          drop_at[t + 1] = acc ? 2 : rx_code;
        end
      end
    end
  endtask

  task automatic step(input logic b, input logic [7:0] d);
    logic [NP-1:0] pr;
    pr = pr_rnd ? NP'($urandom_range(0, 15)) : pr_v;
    bnd_plse = b; data_in = d; proceed = pr;
    model_expect(tcur);
    @(negedge clk);
    chk("ack", ack, ack_at.exists(tcur));
    chk("pkt_drop", pkt_drop, drop_at.exists(tcur));
    if (drop_at.exists(tcur))
      chk("drop_code", drop_code, drop_at[tcur]);
    chk("newdata_len", newdata_len, e_len);
    chk("data_out", data_out, e_data);
    for (int p = 0; p < NP; p++)
      if (newdata_len[p*LW +: LW] != '0) ann_cnt[p]++;
    if (pkt_drop && drop_code == 2'd3) drop3_cnt++;
    model_ingest(tcur, b, d, pr);
    @(posedge clk); #1;
    tcur++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send_pkt(input int hdr, input int n,
                          input logic [7:0] base, input bit rnd);
    step(1'b1, 8'(hdr));
    for (int i = 0; i < n; i++)
      step(i == n - 1, rnd ? 8'($urandom) : base + 8'(i));
  endtask

  task automatic do_reset();
    rst_b = 1'b1; bnd_plse = 1'b0; data_in = '0; proceed = '0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_drop", {pkt_drop, drop_code}, 0);
    chk("rst_len", newdata_len, 0);
    chk("rst_data", data_out, 0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    model_reset();
    tcur = 0;
  endtask

  task automatic clr_cnt();
    for (int p = 0; p < NP; p++) ann_cnt[p] = 0;
    drop3_cnt = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    idle(2);

    clr_cnt();
    send_pkt(2, 3, 8'hA1, 0);
    idle(5); pr_v = 4'b0010; idle(8); pr_v = '0;
    chk("t1_ann_p2", ann_cnt[1], 1);
    chk("t1_ann_other", ann_cnt[0] + ann_cnt[2] + ann_cnt[3], 0);

    clr_cnt();
    send_pkt(5, 4, 8'h50, 0);
    idle(6);
    chk("t2_ann_none",
        ann_cnt[0] + ann_cnt[1] + ann_cnt[2] + ann_cnt[3], 0);

    clr_cnt();
    send_pkt(1, 17, 8'h10, 0);
    send_pkt(1, 2, 8'h31, 0);
    pr_v = 4'b0001; idle(10); pr_v = '0;
    chk("t3_ann_p1", ann_cnt[0], 1);

    clr_cnt();
    for (int k = 0; k < 5; k++) send_pkt(3, 16, 8'(k * 16), 0);
    idle(4); pr_v = 4'b0100; idle(60); pr_v = '0;
    chk("t4_ann_p3", ann_cnt[2], 2);
    chk("t4_drop3", drop3_cnt, 3);

    clr_cnt();
    for (int p = 1; p <= NP; p++) send_pkt(p, 1, 8'(8'hC0 + p), 0);
    idle(4); pr_v = 4'b1111; idle(10); pr_v = '0;
    for (int p = 0; p < NP; p++) chk("t5_ann", ann_cnt[p], 1);

    send_pkt(4, 10, 8'h70, 0);
    pr_v = 4'b1000;
    idle(6);
    do_reset();
    send_pkt(4, 3, 8'hE1, 0);
    idle(12); pr_v = '0;

    do_reset();
    pr_rnd = 1;
    for (int k = 0; k < 60; k++) begin
      send_pkt($urandom_range(0, 5), $urandom_range(1, 18),
               8'h00, 1);
      idle($urandom_range(0, 3));
    end
    pr_rnd = 0; pr_v = 4'b1111;
    idle(150);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
